vm_proj_router_n: RTL and testbench
===================================

Name: vm_proj_router_n

Overview:
- Parametrised successor of the fixed three-way VM projection router.
- Reads one event's projections sequentially from the projection memory. Routes each projection's VM-local field to one of NVM virtual-module memories, chosen by a selector field.
- Each VM memory is double-buffered in two pages, one per event. Per-channel fill counters, overflow detection and done/busy handshake to the sequencer.

Parameters:
- PROJ_W, 54, projection word width
- ADDR_W, 9, address width of the projection and VM memories; MSB of each VM write address is the page bit
- NVM, 3, number of VM output channels, 1..8
- SEL_W, 2, selector field width, must satisfy 2**SEL_W >= NVM
- SEL_LSB, 50, LSB of the selector field in the projection word
- VM_W, 13, VM projection word width
- VM_LSB, 0, LSB of the VM field in the projection word
- RD_LAT, 2, projection memory read latency in clocks, 1..4

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- en_proc  in  1  start-of-event pulse
- n_proj  in  ADDR_W  number of projections in this event
- read_projection  out  ADDR_W  projection memory read address
- projection  in  PROJ_W  projection memory read data
- wr_en  out  NVM  per-channel VM write enable
- wr_add  out  NVM*ADDR_W  per-channel write address; channel k occupies bits [k*ADDR_W +: ADDR_W]
- vm_projection  out  VM_W  VM data, shared by all channels
- busy  out  1  event in progress
- done  out  1  one-cycle end-of-event pulse
- vm_count  out  NVM*ADDR_W  per-channel words written in the current/last event
- overflow  out  NVM  sticky per-channel full flag
- dropped  out  1  sticky: selector >= NVM was seen

Behaviour:
- Reset (reset=0, async): state IDLE; all outputs 0; read_projection=0; page=0; all counters cleared.
- FSM states: IDLE, READ, DRAIN, DONE.
- IDLE:
  - en_proc=1 latches n_proj, toggles page, clears vm_count, overflow and dropped.
  - Goes to READ if n_proj!=0, otherwise to DONE.
  - busy=1 from the cycle after en_proc until the DONE cycle inclusive.
- READ:
  - read_projection takes 0,1,...,n_proj-1, one per clock.
  - Each issued address enters an RD_LAT-deep valid shift register.
  - After issuing address n_proj-1, go to DRAIN.
- DRAIN: wait until the valid pipeline is empty, then go to DONE.
- DONE: done=1 for one cycle, then IDLE.
- en_proc is ignored while not in IDLE.
- Data path:
  - Data for address A is present on projection RD_LAT clocks after A is driven.
  - The router registers its outputs on the next edge, so wr_en asserts RD_LAT+1 clocks after the address.
  - sel = projection[SEL_LSB +: SEL_W]; vm_projection <= projection[VM_LSB +: VM_W].
  - If sel < NVM and channel sel is not full: wr_en[sel]=1; wr_add[sel] = {page, cnt[sel][ADDR_W-2:0]}; cnt[sel]++.
  - At most one wr_en bit is high per cycle. The wr_add of non-writing channels holds its last value.
- Full rule:
  - Per-page depth is 2**(ADDR_W-1).
  - A channel with cnt == 2**(ADDR_W-1) suppresses the write and sets overflow[k].
  - Its count stays saturated; other channels are unaffected.
- If sel >= NVM: no write, dropped=1.
- vm_count mirrors cnt. It is held after done until the next accepted en_proc.
- page persists across events. Consumers read the page opposite to the one being written.
- Reset mid-event: immediate return to IDLE; partial writes are abandoned and page returns to 0.

Test Plan:
1. Reset then idle: reset low 3 cycles, release, no en_proc -> all outputs 0, busy=0, no wr_en for 20 cycles.
2. Basic routing, NVM=3, RD_LAT=2:
   - Stimulus: n_proj=6, selectors 0,1,2,0,1,2, VM fields 0x001..0x006.
   - Required: wr_en pulses in the same order, first one 3 clocks after read_projection=0.
   - wr_add per channel = {1,0} then {1,1}; vm_count = 2,2,2; done exactly one cycle after the last write.
3. Page toggle: run two events back-to-back with n_proj=2, sel=0 -> first event addresses 0x100,0x101; second event 0x000,0x001.
4. Overflow, ADDR_W=4 (depth 8):
   - Stimulus: 10 projections, all sel=1.
   - Required: 8 writes, overflow=3'b010, vm_count[1]=8; channel 0 and 2 flags stay clear.
5. Invalid selector and empty event:
   - sel=3 with NVM=3 -> no wr_en, dropped=1.
   - n_proj=0 -> busy for one cycle, done pulse, no reads.
6. Mid-event reset and ignored start:
   - Assert reset during READ -> all outputs 0 within the same cycle (async), page=0.
   - en_proc during busy -> no restart and n_proj is not re-latched.

Source files
------------

// File: rtl/vm_proj_router_n.sv
// Routes each projection of an event to one of NVM double-buffered VM memories,
// chosen by the projection's selector field; tracks per-channel fill and overflow.
module vm_proj_router_n #(
  parameter int PROJ_W  = 54,
  parameter int ADDR_W  = 9,
  parameter int NVM     = 3,
  parameter int SEL_W   = 2,
  parameter int SEL_LSB = 50,
  parameter int VM_W    = 13,
  parameter int VM_LSB  = 0,
  parameter int RD_LAT  = 2
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    en_proc,
  input  logic [ADDR_W-1:0]       n_proj,
  output logic [ADDR_W-1:0]       read_projection,
  input  logic [PROJ_W-1:0]       projection,
  output logic [NVM-1:0]          wr_en,
  output logic [NVM*ADDR_W-1:0]   wr_add,
  output logic [VM_W-1:0]         vm_projection,
  output logic                    busy,
  output logic                    done,
  output logic [NVM*ADDR_W-1:0]   vm_count,
  output logic [NVM-1:0]          overflow,
  output logic                    dropped
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_READ  = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;
  localparam logic [1:0] S_DONE  = 2'd3;

  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] FULL     = {1'b1, {(ADDR_W-1){1'b0}}};
  localparam logic [SEL_W:0]    NVM_L    = (SEL_W+1)'(NVM);

  logic [1:0]        state;
  logic [ADDR_W-1:0] n_lat;
  logic              page;
  logic [RD_LAT-1:0] vld_p;
  logic [ADDR_W-1:0] cnt [NVM];
  logic [SEL_W-1:0]  sel;
  logic              sel_ok;
  logic              vld_last;
  logic              start;
  logic              unused_bits;

  assign sel         = projection[SEL_LSB +: SEL_W];
  assign sel_ok      = ({1'b0, sel} < NVM_L);
  assign vld_last    = vld_p[RD_LAT-1];
  assign start       = (state == S_IDLE) && en_proc;
  assign busy        = (state != S_IDLE);
  assign done        = (state == S_DONE);
  assign unused_bits = ^projection;

  // Control: address issue, read-valid pipeline and page bit
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state           <= S_IDLE;
      n_lat           <= '0;
      page            <= 1'b0;
      read_projection <= '0;
      vld_p           <= '0;
    end else begin
      vld_p <= (vld_p << 1) | RD_LAT'(state == S_READ);
      case (state)
        S_IDLE: begin
          if (en_proc) begin
            n_lat           <= n_proj;
            page            <= ~page;
            read_projection <= '0;
            state           <= (n_proj != '0) ? S_READ : S_DONE;
          end
        end
        S_READ: begin
          if (read_projection == n_lat - ADDR_ONE) state <= S_DRAIN;
          else read_projection <= read_projection + ADDR_ONE;
        end
        S_DRAIN: begin
          if (vld_p == '0) state <= S_DONE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Write stage: registered one clock after read data arrives
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_en         <= '0;
      wr_add        <= '0;
      vm_projection <= '0;
      overflow      <= '0;
      dropped       <= 1'b0;
      for (int k = 0; k < NVM; k++) cnt[k] <= '0;
    end else begin
      wr_en <= '0;
      if (start) begin
        overflow <= '0;
        dropped  <= 1'b0;
        for (int k = 0; k < NVM; k++) cnt[k] <= '0;
      end else if (vld_last) begin
        vm_projection <= projection[VM_LSB +: VM_W];
        if (!sel_ok) begin
          dropped <= 1'b1;
        end else begin
          for (int k = 0; k < NVM; k++) begin
            if (sel == SEL_W'(k)) begin
              if (cnt[k] == FULL) begin
                overflow[k] <= 1'b1;
              end else begin
                wr_en[k]                   <= 1'b1;
                wr_add[k*ADDR_W +: ADDR_W] <= {page, cnt[k][ADDR_W-2:0]};
                cnt[k]                     <= cnt[k] + ADDR_ONE;
              end
            end
          end
        end
      end
    end
  end

  always_comb begin
    vm_count = '0;
    for (int k = 0; k < NVM; k++) vm_count[k*ADDR_W +: ADDR_W] = cnt[k];
  end

endmodule

// File: tb/tb_vm_proj_router_n.sv
// Directed bench for vm_proj_router_n: a default-size instance plus an ADDR_W=4
// instance for the channel-full case, each fed by a RD_LAT=2 projection memory model.
module tb_vm_proj_router_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic reset;

  logic        en_proc;
  logic [8:0]  n_proj;
  logic [8:0]  read_projection;
  logic [53:0] projection;
  logic [2:0]  wr_en;
  logic [26:0] wr_add;
  logic [12:0] vm_projection;
  logic        busy, done;
  logic [26:0] vm_count;
  logic [2:0]  overflow;
  logic        dropped;

  logic        en_s;
  logic [3:0]  n_s;
  logic [3:0]  rd_s;
  logic [53:0] proj_s;
  logic [2:0]  wr_en_s;
  logic [11:0] wr_add_s;
  logic [12:0] vm_proj_s;
  logic        busy_s, done_s;
  logic [11:0] vm_count_s;
  logic [2:0]  overflow_s;
  logic        dropped_s;

  int errors = 0;
  int checks = 0;

  vm_proj_router_n dut (
    .clk(clk), .reset(reset), .en_proc(en_proc), .n_proj(n_proj),
    .read_projection(read_projection), .projection(projection),
    .wr_en(wr_en), .wr_add(wr_add), .vm_projection(vm_projection),
    .busy(busy), .done(done), .vm_count(vm_count),
    .overflow(overflow), .dropped(dropped)
  );

  vm_proj_router_n #(.ADDR_W(4)) dut_s (
    .clk(clk), .reset(reset), .en_proc(en_s), .n_proj(n_s),
    .read_projection(rd_s), .projection(proj_s),
    .wr_en(wr_en_s), .wr_add(wr_add_s), .vm_projection(vm_proj_s),
    .busy(busy_s), .done(done_s), .vm_count(vm_count_s),
    .overflow(overflow_s), .dropped(dropped_s)
  );

  // Projection memories with two clocks of read latency
  logic [53:0] mem   [512];
  logic [53:0] mem_s [16];
  logic [53:0] d1, d2, d1s, d2s;
  always @(posedge clk) begin
    d1  <= mem[read_projection];
    d2  <= d1;
    d1s <= mem_s[rd_s];
    d2s <= d1s;
  end
  assign projection = d2;
  assign proj_s     = d2s;

  function automatic logic [53:0] mk(input logic [1:0] s, input logic [12:0] v);
    mk = {2'b00, s, 37'b0, v};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic seen;
    reset = 1'b0; en_proc = 1'b0; n_proj = '0; en_s = 1'b0; n_s = '0;
    repeat (3) tick();
    reset = 1'b1;
    tick();
    checks++; if (read_projection !== 9'h0) begin errors++; $display("FAIL reset_rd: got %h expected 0", read_projection); end
    checks++; if (wr_en !== 3'b0) begin errors++; $display("FAIL reset_wr_en: got %b expected 000", wr_en); end
    checks++; if (wr_add !== 27'h0) begin errors++; $display("FAIL reset_wr_add: got %h expected 0", wr_add); end
    checks++; if (vm_projection !== 13'h0) begin errors++; $display("FAIL reset_vm: got %h expected 0", vm_projection); end
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL reset_busy_done: got %b%b expected 00", busy, done); end
    checks++; if (vm_count !== 27'h0) begin errors++; $display("FAIL reset_count: got %h expected 0", vm_count); end
    checks++; if (overflow !== 3'b0 || dropped !== 1'b0) begin errors++; $display("FAIL reset_flags: got %b %b expected 000 0", overflow, dropped); end
    seen = 1'b0;
    repeat (20) begin
      tick();
      if (wr_en !== 3'b0 || wr_en_s !== 3'b0 || busy !== 1'b0) seen = 1'b1;
    end
    checks++; if (seen !== 1'b0) begin errors++; $display("FAIL idle_quiet: got activity=%b expected 0", seen); end
  endtask

  task automatic test_basic_routing();
    logic [2:0] exp_we;
    logic [8:0] exp_add;
    int ch;
    for (int i = 0; i < 6; i++) mem[i] = mk(2'(i % 3), 13'(i + 1));
    en_proc = 1'b1; n_proj = 9'd6;
    tick();
    en_proc = 1'b0; n_proj = '0;
    checks++; if (read_projection !== 9'd0 || busy !== 1'b1) begin errors++; $display("FAIL basic_start: got rd=%0d busy=%b expected 0 1", read_projection, busy); end
    for (int c = 1; c <= 14; c++) begin
      tick();
      if (c <= 5) begin
        checks++; if (read_projection !== 9'(c)) begin errors++; $display("FAIL basic_rd c=%0d: got %0d expected %0d", c, read_projection, c); end
      end
      exp_we = (c >= 3 && c <= 8) ? 3'(1 << ((c - 3) % 3)) : 3'b000;
      checks++; if (wr_en !== exp_we) begin errors++; $display("FAIL basic_wr_en c=%0d: got %b expected %b", c, wr_en, exp_we); end
      if (exp_we != 3'b000) begin
        ch = (c - 3) % 3;
        exp_add = {1'b1, 8'((c - 3) / 3)};
        checks++; if (wr_add[ch*9 +: 9] !== exp_add) begin errors++; $display("FAIL basic_wr_add c=%0d: got %h expected %h", c, wr_add[ch*9 +: 9], exp_add); end
        checks++; if (vm_projection !== 13'(c - 2)) begin errors++; $display("FAIL basic_vm c=%0d: got %h expected %h", c, vm_projection, c - 2); end
      end
      checks++; if (done !== (c == 9)) begin errors++; $display("FAIL basic_done c=%0d: got %b expected %b", c, done, c == 9); end
    end
    checks++; if (vm_count !== {9'd2, 9'd2, 9'd2}) begin errors++; $display("FAIL basic_count: got %h expected %h", vm_count, {9'd2, 9'd2, 9'd2}); end
    checks++; if (busy !== 1'b0 || overflow !== 3'b0 || dropped !== 1'b0) begin errors++; $display("FAIL basic_end: got busy=%b ovf=%b drop=%b expected 0 000 0", busy, overflow, dropped); end
  endtask

  task automatic test_page_toggle();
    int nw;
    logic got_done;
    logic [8:0] exp_add;
    reset = 1'b0; tick(); reset = 1'b1; tick();
    mem[0] = mk(2'd0, 13'h0A);
    mem[1] = mk(2'd0, 13'h0B);
    for (int ev = 0; ev < 2; ev++) begin
      en_proc = 1'b1; n_proj = 9'd2;
      tick();
      en_proc = 1'b0;
      nw = 0; got_done = 1'b0;
      for (int c = 0; c < 15 && !got_done; c++) begin
        tick();
        if (wr_en[0]) begin
          exp_add = ((ev == 0) ? 9'h100 : 9'h000) + 9'(nw);
          checks++; if (wr_add[8:0] !== exp_add) begin errors++; $display("FAIL page_add ev=%0d: got %h expected %h", ev, wr_add[8:0], exp_add); end
          nw++;
        end
        if (done) got_done = 1'b1;
      end
      checks++; if (nw != 2 || !got_done) begin errors++; $display("FAIL page_event ev=%0d: got writes=%0d done=%b expected 2 1", ev, nw, got_done); end
      tick();
    end
  endtask

  task automatic test_overflow();
    int nw;
    logic got_done, bad_ch;
    for (int i = 0; i < 10; i++) mem_s[i] = mk(2'd1, 13'(i));
    en_s = 1'b1; n_s = 4'd10;
    tick();
    en_s = 1'b0;
    nw = 0; got_done = 1'b0; bad_ch = 1'b0;
    for (int c = 0; c < 40 && !got_done; c++) begin
      tick();
      if (wr_en_s != 3'b000) begin
        nw++;
        if (wr_en_s != 3'b010) bad_ch = 1'b1;
      end
      if (done_s) got_done = 1'b1;
    end
    checks++; if (nw != 8 || !got_done) begin errors++; $display("FAIL ovf_writes: got %0d done=%b expected 8 1", nw, got_done); end
    checks++; if (bad_ch !== 1'b0) begin errors++; $display("FAIL ovf_channel: got stray channel=%b expected 0", bad_ch); end
    checks++; if (overflow_s !== 3'b010) begin errors++; $display("FAIL ovf_flag: got %b expected 010", overflow_s); end
    checks++; if (vm_count_s !== 12'h080) begin errors++; $display("FAIL ovf_count: got %h expected 080", vm_count_s); end
    checks++; if (wr_add_s[7:4] !== 4'hF) begin errors++; $display("FAIL ovf_last_add: got %h expected f", wr_add_s[7:4]); end
    checks++; if (dropped_s !== 1'b0) begin errors++; $display("FAIL ovf_dropped: got %b expected 0", dropped_s); end
    tick();
  endtask

  task automatic test_invalid_and_empty();
    int nw;
    logic got_done;
    mem[0] = mk(2'd3, 13'h55);
    en_proc = 1'b1; n_proj = 9'd1;
    tick();
    en_proc = 1'b0;
    nw = 0; got_done = 1'b0;
    for (int c = 0; c < 15 && !got_done; c++) begin
      tick();
      if (wr_en != 3'b000) nw++;
      if (done) got_done = 1'b1;
    end
    checks++; if (nw != 0 || !got_done) begin errors++; $display("FAIL drop_writes: got %0d done=%b expected 0 1", nw, got_done); end
    checks++; if (dropped !== 1'b1) begin errors++; $display("FAIL drop_flag: got %b expected 1", dropped); end
    checks++; if (vm_count !== 27'h0 || overflow !== 3'b0) begin errors++; $display("FAIL drop_count: got %h %b expected 0 000", vm_count, overflow); end
    tick();
    en_proc = 1'b1; n_proj = 9'd0;
    tick();
    en_proc = 1'b0;
    checks++; if (busy !== 1'b1 || done !== 1'b1) begin errors++; $display("FAIL empty_pulse: got busy=%b done=%b expected 1 1", busy, done); end
    checks++; if (dropped !== 1'b0 || read_projection !== 9'd0) begin errors++; $display("FAIL empty_clear: got drop=%b rd=%0d expected 0 0", dropped, read_projection); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL empty_end: got busy=%b done=%b expected 0 0", busy, done); end
  endtask

  task automatic test_midreset_ignored();
    int nw;
    logic got_done;
    for (int i = 0; i < 6; i++) mem[i] = mk(2'd0, 13'(12'h20 + i));
    en_proc = 1'b1; n_proj = 9'd6;
    tick();
    en_proc = 1'b0;
    repeat (5) tick();
    checks++; if (wr_en !== 3'b001 || vm_count[8:0] !== 9'd3) begin errors++; $display("FAIL mid_pre: got we=%b cnt=%0d expected 001 3", wr_en, vm_count[8:0]); end
    reset = 1'b0;
    #1;
    checks++; if (wr_en !== 3'b0 || busy !== 1'b0 || read_projection !== 9'd0) begin errors++; $display("FAIL mid_reset_ctl: got we=%b busy=%b rd=%0d expected 000 0 0", wr_en, busy, read_projection); end
    checks++; if (vm_count !== 27'h0 || wr_add !== 27'h0 || vm_projection !== 13'h0) begin errors++; $display("FAIL mid_reset_data: got cnt=%h add=%h vm=%h expected 0", vm_count, wr_add, vm_projection); end
    tick();
    reset = 1'b1;
    tick();
    en_proc = 1'b1; n_proj = 9'd1;
    tick();
    en_proc = 1'b0;
    got_done = 1'b0; nw = 0;
    for (int c = 0; c < 15 && !got_done; c++) begin
      tick();
      if (wr_en[0]) begin
        nw++;
        checks++; if (wr_add[8:0] !== 9'h100) begin errors++; $display("FAIL mid_page: got %h expected 100", wr_add[8:0]); end
      end
      if (done) got_done = 1'b1;
    end
    checks++; if (nw != 1 || !got_done) begin errors++; $display("FAIL mid_event: got %0d done=%b expected 1 1", nw, got_done); end
    tick();
    en_proc = 1'b1; n_proj = 9'd4;
    tick();
    en_proc = 1'b0;
    tick();
    en_proc = 1'b1; n_proj = 9'd1;
    tick();
    en_proc = 1'b0;
    got_done = 1'b0; nw = 0;
    for (int c = 0; c < 20 && !got_done; c++) begin
      tick();
      if (wr_en[0]) nw++;
      if (done) got_done = 1'b1;
    end
    checks++; if (nw != 4 || !got_done) begin errors++; $display("FAIL ignore_writes: got %0d done=%b expected 4 1", nw, got_done); end
    checks++; if (vm_count[8:0] !== 9'd4 || wr_add[8:0] !== 9'h003) begin errors++; $display("FAIL ignore_count: got cnt=%0d add=%h expected 4 003", vm_count[8:0], wr_add[8:0]); end
    repeat (3) tick();
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL ignore_restart: got busy=%b expected 0", busy); end
  endtask

  initial begin
    test_reset();
    test_basic_routing();
    test_page_toggle();
    test_overflow();
    test_invalid_and_empty();
    test_midreset_ignored();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
